// File: rtl/riscv_configs_pkg.sv
// Shared definitions for the RV32I pipeline hazard/stall controller.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package riscv_configs;

    // Pipeline stage indices, IF first.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int              REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Stall/flush bit-vector ordering {PC, IFID, IDEX, EXMEM, MEMWB}.
    localparam int CTL_W   = 5;
    localparam int V_PC    = 4;
    localparam int V_IFID  = 3;
    localparam int V_IDEX  = 2;
    localparam int V_EXMEM = 1;
    localparam int V_MEMWB = 0;

    typedef logic [CTL_W-1:0] ctl_vec_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } lu_state_t;

    // True when a source operand read in ID matches a non-x0 destination.
    function automatic logic src_hits(input logic [REG_ADDR_W-1:0] rs,
                                      input logic                  used,
                                      input logic [REG_ADDR_W-1:0] rd);
        return used && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count visible the cycle after i_inc.
// Backpressure: none; increments past all-ones are dropped.
//
// Ports: i_clk, i_rst (async, active-high), i_clr (sync clear, wins over
// i_inc), i_inc (count one), o_cnt (current count).
module riscv_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != {CNT_W{1'b1}})) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/riscv_pipeline_control.sv
// Hazard and stall/flush controller for the RV32I 5-stage pipeline.
// Latency: stall/flush are combinational (same cycle); counters and watchdog are registered.
// Backpressure: imem/dmem wait hold the pipeline; dmem wait freezes the controller itself.
//
// Ports: i_clk, i_rst (async, active-high); ID operand indices/used flags,
// EX rd/load/redirect, imem/dmem handshakes; o_stall_* (1 = hold),
// o_flush_* (sync clear), o_dmem_timeout pulse, o_stall_cycles, o_flush_count.
// LOAD_USE_BUBBLES is legal in 1..3; DMEM_TIMEOUT=0 disables the watchdog.
module riscv_pipeline_control
    import riscv_configs::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int DMEM_TIMEOUT     = 0,
    parameter int CNT_W            = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic                  i_id_rs1_used,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_is_load,
    input  logic                  i_ex_redirect,
    input  logic                  i_imem_ready,
    input  logic                  i_mem_req,
    input  logic                  i_dmem_ready,
    output logic                  o_stall_pc,
    output logic                  o_stall_ifid,
    output logic                  o_stall_idex,
    output logic                  o_stall_exmem,
    output logic                  o_stall_memwb,
    output logic                  o_flush_ifid,
    output logic                  o_flush_idex,
    output logic                  o_flush_exmem,
    output logic                  o_flush_memwb,
    output logic                  o_dmem_timeout,
    output logic [CNT_W-1:0]      o_stall_cycles,
    output logic [CNT_W-1:0]      o_flush_count
);

    localparam int BUB_W  = 2;
    localparam int WAIT_W = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;

    lu_state_t        state_q, state_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    ctl_vec_t         stall_v, flush_v;
    logic             dwait;
    logic             lu_hazard;
    logic             redirect_acc;

    assign dwait        = i_mem_req && !i_dmem_ready;
    assign lu_hazard    = i_ex_is_load &&
                          (src_hits(i_id_rs1, i_id_rs1_used, i_ex_rd) ||
                           src_hits(i_id_rs2, i_id_rs2_used, i_ex_rd));
    // A redirect during a dmem wait is dropped: EX is held and re-presents it.
    assign redirect_acc = i_ex_redirect && !dwait;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The first bubble is issued from RUN; BUBBLE covers the remaining ones.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        if (!dwait) begin
            if (i_ex_redirect) begin
                state_d = ST_RUN;
                bub_d   = '0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (lu_hazard && (LOAD_USE_BUBBLES > 1)) begin
                            state_d = ST_BUBBLE;
                            bub_d   = BUB_W'(LOAD_USE_BUBBLES - 1);
                        end
                    end
                    ST_BUBBLE: begin
                        bub_d = bub_q - BUB_W'(1);
                        if (bub_q == BUB_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        bub_d   = '0;
                    end
                endcase
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_v = '0;
        flush_v = '0;
        if (i_rst) begin
            flush_v = '1;
        end else if (dwait) begin
            stall_v[V_PC]    = 1'b1;
            stall_v[V_IFID]  = 1'b1;
            stall_v[V_IDEX]  = 1'b1;
            stall_v[V_EXMEM] = 1'b1;
            flush_v[V_MEMWB] = 1'b1;
        end else if (i_ex_redirect) begin
            flush_v[V_IFID] = 1'b1;
            flush_v[V_IDEX] = 1'b1;
        end else begin
            if ((state_q == ST_RUN && lu_hazard) || state_q == ST_BUBBLE) begin
                stall_v[V_PC]   = 1'b1;
                stall_v[V_IFID] = 1'b1;
                flush_v[V_IDEX] = 1'b1;
            end
            if (!i_imem_ready) begin
                stall_v[V_PC] = 1'b1;
                // A hold on IF/ID beats a clear of the same register.
                flush_v[V_IFID] = !stall_v[V_IFID];
            end
        end
    end

    assign o_stall_pc    = stall_v[V_PC];
    assign o_stall_ifid  = stall_v[V_IFID];
    assign o_stall_idex  = stall_v[V_IDEX];
    assign o_stall_exmem = stall_v[V_EXMEM];
    assign o_stall_memwb = stall_v[V_MEMWB];
    assign o_flush_ifid  = flush_v[V_IFID];
    assign o_flush_idex  = flush_v[V_IDEX];
    assign o_flush_exmem = flush_v[V_EXMEM];
    assign o_flush_memwb = flush_v[V_MEMWB];

    // ---------------- Data-memory watchdog ----------------
    generate
        if (DMEM_TIMEOUT > 0) begin : g_wdog
            logic [WAIT_W-1:0] wait_q;
            // Counter restarts after each pulse so a long wait pulses periodically.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    wait_q         <= '0;
                    o_dmem_timeout <= 1'b0;
                end else if (dwait) begin
                    if (wait_q == WAIT_W'(DMEM_TIMEOUT - 1)) begin
                        wait_q         <= '0;
                        o_dmem_timeout <= 1'b1;
                    end else begin
                        wait_q         <= wait_q + WAIT_W'(1);
                        o_dmem_timeout <= 1'b0;
                    end
                end else begin
                    wait_q         <= '0;
                    o_dmem_timeout <= 1'b0;
                end
            end
        end else begin : g_no_wdog
            assign o_dmem_timeout = 1'b0;
        end
    endgenerate

    // ---------------- Performance counters ----------------
    riscv_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_inc (stall_v[V_PC]),
        .o_cnt (o_stall_cycles)
    );

    riscv_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_inc (redirect_acc),
        .o_cnt (o_flush_count)
    );

endmodule

// File: tb/tb_riscv_pipeline_control.sv
// Self-checking bench: instance A (1 bubble, watchdog 4, 32-bit counters)
// and instance B (2 bubbles, no watchdog, 4-bit counters) share the inputs.
// Table vectors, hand sequences and random cycles are checked against a model.
module tb_riscv_pipeline_control;

    typedef struct {
        logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd;  logic ld; logic redir; logic im; logic mr; logic dm;
    } in_t;

    typedef struct {
        in_t        i;
        logic [4:0] st;
        logic [4:0] fl;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
    logic       i_id_rs1_used, i_id_rs2_used, i_ex_is_load, i_ex_redirect;
    logic       i_imem_ready, i_mem_req, i_dmem_ready;

    logic a_spc, a_sifid, a_sidex, a_sexmem, a_smemwb;
    logic a_fifid, a_fidex, a_fexmem, a_fmemwb, a_to;
    logic [31:0] a_sc, a_fc;
    logic b_spc, b_sifid, b_sidex, b_sexmem, b_smemwb;
    logic b_fifid, b_fidex, b_fexmem, b_fmemwb, b_to;
    logic [3:0] b_sc, b_fc;

    wire [4:0] a_st = {a_spc, a_sifid, a_sidex, a_sexmem, a_smemwb};
    wire [4:0] a_fl = {1'b0, a_fifid, a_fidex, a_fexmem, a_fmemwb};
    wire [4:0] b_st = {b_spc, b_sifid, b_sidex, b_sexmem, b_smemwb};
    wire [4:0] b_fl = {1'b0, b_fifid, b_fidex, b_fexmem, b_fmemwb};

    always #5 i_clk = ~i_clk;

    riscv_pipeline_control #(.LOAD_USE_BUBBLES(1), .DMEM_TIMEOUT(4), .CNT_W(32)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs1(i_id_rs1), .i_id_rs1_used(i_id_rs1_used),
        .i_id_rs2(i_id_rs2), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load), .i_ex_redirect(i_ex_redirect),
        .i_imem_ready(i_imem_ready), .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
        .o_stall_pc(a_spc), .o_stall_ifid(a_sifid), .o_stall_idex(a_sidex),
        .o_stall_exmem(a_sexmem), .o_stall_memwb(a_smemwb),
        .o_flush_ifid(a_fifid), .o_flush_idex(a_fidex),
        .o_flush_exmem(a_fexmem), .o_flush_memwb(a_fmemwb),
        .o_dmem_timeout(a_to), .o_stall_cycles(a_sc), .o_flush_count(a_fc)
    );

    riscv_pipeline_control #(.LOAD_USE_BUBBLES(2), .DMEM_TIMEOUT(0), .CNT_W(4)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs1(i_id_rs1), .i_id_rs1_used(i_id_rs1_used),
        .i_id_rs2(i_id_rs2), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load), .i_ex_redirect(i_ex_redirect),
        .i_imem_ready(i_imem_ready), .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
        .o_stall_pc(b_spc), .o_stall_ifid(b_sifid), .o_stall_idex(b_sidex),
        .o_stall_exmem(b_sexmem), .o_stall_memwb(b_smemwb),
        .o_flush_ifid(b_fifid), .o_flush_idex(b_fidex),
        .o_flush_exmem(b_fexmem), .o_flush_memwb(b_fmemwb),
        .o_dmem_timeout(b_to), .o_stall_cycles(b_sc), .o_flush_count(b_fc)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, one slot per instance: bubbles still owed, wait
    // cycles seen, counters and the expected watchdog output.
    int     m_lub [2] = '{1, 2};
    int     m_tmo [2] = '{4, 0};
    longint m_max [2] = '{64'hFFFF_FFFF, 15};
    int     m_left[2];
    int     m_wc  [2];
    longint m_sc  [2];
    longint m_fc  [2];
    logic   m_to  [2];
    in_t    cur;
    logic   cur_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(int rs1, bit u1, int rs2, bit u2, int rd, bit ld,
                               bit redir, bit im, bit mr, bit dm);
        in_t v;
        v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
        v.rd = 5'(rd); v.ld = ld; v.redir = redir; v.im = im; v.mr = mr; v.dm = dm;
        return v;
    endfunction

    task automatic model_out(input int k, input in_t v, input logic rst,
                             output logic [4:0] st, output logic [4:0] fl);
        bit hz, dw, b;
        hz = v.ld && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        dw = v.mr && !v.dm;
        b  = (m_left[k] > 0) || hz;
        if (rst)          begin st = 5'b00000; fl = 5'b01111; end
        else if (dw)      begin st = 5'b11110; fl = 5'b00001; end
        else if (v.redir) begin st = 5'b00000; fl = 5'b01100; end
        else begin
            st = {b || !v.im, b, 3'b000};
            fl = {1'b0, !v.im && !b, b, 2'b00};
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_wc[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_to[k] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs and compare everything mid-cycle.
    task automatic apply(input logic rst, input in_t v);
        logic [4:0] st, fl;
        cur = v; cur_rst = rst;
        i_rst = rst;
        i_id_rs1 = v.rs1; i_id_rs1_used = v.u1; i_id_rs2 = v.rs2; i_id_rs2_used = v.u2;
        i_ex_rd = v.rd; i_ex_is_load = v.ld; i_ex_redirect = v.redir;
        i_imem_ready = v.im; i_mem_req = v.mr; i_dmem_ready = v.dm;
        if (rst) model_clear();
        #2;
        model_out(0, v, rst, st, fl);
        chk("a_stall", a_st, st);
        chk("a_flush", a_fl, fl);
        chk("a_stall_cycles", a_sc, m_sc[0]);
        chk("a_flush_count", a_fc, m_fc[0]);
        chk("a_timeout", a_to, m_to[0]);
        model_out(1, v, rst, st, fl);
        chk("b_stall", b_st, st);
        chk("b_flush", b_fl, fl);
        chk("b_stall_cycles", b_sc, m_sc[1]);
        chk("b_flush_count", b_fc, m_fc[1]);
        chk("b_timeout", b_to, m_to[1]);
    endtask

    // Clock edge: advance the model from the inputs held this cycle.
    task automatic tick();
        logic [4:0] st, fl;
        bit hz, dw;
        @(posedge i_clk);
        if (cur_rst) model_clear();
        else begin
            hz = cur.ld && cur.rd != 0 &&
                 ((cur.u1 && cur.rs1 == cur.rd) || (cur.u2 && cur.rs2 == cur.rd));
            dw = cur.mr && !cur.dm;
            for (int k = 0; k < 2; k++) begin
                model_out(k, cur, 1'b0, st, fl);
                if (st[4] && m_sc[k] < m_max[k]) m_sc[k]++;
                if (!dw) begin
                    if (cur.redir) begin
                        m_left[k] = 0;
                        if (m_fc[k] < m_max[k]) m_fc[k]++;
                    end else if (m_left[k] > 0) m_left[k]--;
                    else if (hz) m_left[k] = m_lub[k] - 1;
                end
                if (m_tmo[k] > 0 && dw) begin
                    m_wc[k]++;
                    m_to[k] = (m_wc[k] == m_tmo[k]);
                    if (m_to[k]) m_wc[k] = 0;
                end else begin
                    m_wc[k] = 0;
                    m_to[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    vec_t tbl[12];
    in_t  idle, haz, dwt;
    logic [8:0] pulses;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        haz  = mk(5, 1, 0, 0, 5, 1, 0, 1, 0, 1);
        dwt  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        tbl[0]  = '{mk(1, 1, 2, 1, 3, 0, 0, 1, 0, 1), 5'b00000, 5'b00000};
        tbl[1]  = '{haz,                              5'b11000, 5'b00100};
        tbl[2]  = '{mk(1, 1, 7, 1, 7, 1, 0, 1, 0, 1), 5'b11000, 5'b00100};
        tbl[3]  = '{mk(1, 1, 7, 0, 7, 1, 0, 1, 0, 1), 5'b00000, 5'b00000};
        tbl[4]  = '{mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 1), 5'b00000, 5'b00000};
        tbl[5]  = '{mk(6, 1, 6, 1, 6, 0, 0, 1, 0, 1), 5'b00000, 5'b00000};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 5'b10000, 5'b01000};
        tbl[7]  = '{mk(5, 1, 0, 0, 5, 1, 0, 0, 0, 1), 5'b11000, 5'b00100};
        tbl[8]  = '{mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 1), 5'b00000, 5'b01100};
        tbl[9]  = '{mk(5, 1, 0, 0, 5, 1, 1, 0, 1, 0), 5'b11110, 5'b00001};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 5'b00000, 5'b00000};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), 5'b00000, 5'b01100};

        model_clear();
        apply(1'b1, idle); tick();
        apply(1'b1, idle); tick();

        // Load-use: one bubble on A, two on B, then counters.
        apply(1'b0, idle); tick();
        apply(1'b0, haz);
        chk("lu_a_bubble", a_st, 5'b11000);
        chk("lu_b_bubble1", b_st, 5'b11000);
        tick();
        apply(1'b0, idle);
        chk("lu_a_released", a_st, 5'b00000);
        chk("lu_b_bubble2", b_st, 5'b11000);
        chk("lu_b_flush_idex", b_fidex, 1'b1);
        tick();
        apply(1'b0, idle);
        chk("lu_b_released", b_st, 5'b00000);
        chk("lu_a_cycles", a_sc, 1);
        chk("lu_b_cycles", b_sc, 2);
        tick();
        apply(1'b0, mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 1));
        chk("x0_no_stall", b_st, 5'b00000);
        tick();

        // Redirect while B is in BUBBLE.
        apply(1'b0, haz); tick();
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        chk("redir_b_stall", b_st, 5'b00000);
        chk("redir_b_flush", b_fl, 5'b01100);
        tick();
        apply(1'b0, idle);
        chk("redir_b_run", b_st, 5'b00000);
        chk("redir_b_count", b_fc, 1);
        tick();

        // Data-memory wait inside a bubble, with a redirect held.
        apply(1'b0, haz); tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
            chk("dwait_b_stall", b_st, 5'b11110);
            chk("dwait_b_flush", b_fl, 5'b00001);
            tick();
        end
        apply(1'b0, idle);
        chk("dwait_bubble_resumes", b_st, 5'b11000);
        chk("dwait_redir_ignored", b_fc, 1);
        tick();
        apply(1'b0, idle); tick();

        // Watchdog: 9-cycle wait on A pulses after wait cycles 4 and 8.
        pulses = '0;
        for (int c = 0; c < 9; c++) begin
            apply(1'b0, dwt); tick();
            pulses[c] = a_to;
        end
        chk("wdog_pulses", pulses, 9'b010001000);
        apply(1'b0, idle); tick();

        // Table vectors; A stays in RUN so each row is a pure decode.
        foreach (tbl[n]) begin
            apply(1'b0, tbl[n].i);
            chk($sformatf("tbl%0d_stall", n), a_st, tbl[n].st);
            chk($sformatf("tbl%0d_flush", n), a_fl, tbl[n].fl);
            tick();
        end

        // Reset asserted mid-stall.
        apply(1'b0, haz);
        chk("pre_rst_stall", a_st, 5'b11000);
        apply(1'b1, haz);
        chk("rst_stalls", a_st, 5'b00000);
        chk("rst_flushes", {a_fifid, a_fidex, a_fexmem, a_fmemwb}, 4'b1111);
        tick();
        apply(1'b0, idle);
        chk("rst_a_cycles", a_sc, 0);
        chk("rst_b_flushes", b_fc, 0);
        tick();

        // Random traffic; B's 4-bit counters will saturate.
        for (int c = 0; c < 3000; c++) begin
            in_t v;
            logic r;
            v = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            r = ($urandom_range(0, 299) == 0);
            apply(r, v);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
